mem_access_initiator: RTL
=========================

Name: mem_access_initiator

Overview:
- Initiator (load/store master) for the word-addressed main memory port (`address`, `readEnable`, `writeEnable`, `dataIn`, `dataOut`).
- Accepts byte-addressed load/store requests from the execute stage over a valid/ready handshake.
- Performs alignment checks, byte/half extraction with sign/zero extension, and read-modify-write for sub-word stores.
- Returns a one-cycle response pulse carrying the load data or an error flag.

Parameters:
- ADDR_W, 32, request and memory address width.
- DATA_W, 32, data word width; fixed at 32; byte lanes assume 4.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_signed  in  1  loads only: sign-extend when 1.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_error  out  1  misaligned or reserved-size request.
- mem_address  out  ADDR_W  word index = {2'b00, addr[31:2]}.
- mem_read_enable  out  1  to memory readEnable.
- mem_write_enable  out  1  to memory writeEnable.
- mem_wdata  out  DATA_W  to memory dataIn.
- mem_rdata  in  DATA_W  from memory dataOut; combinational read.

Behaviour:
- Clock `clk`, single domain. Reset `rst` is asynchronous, active-high.
- Reset values: state IDLE, req_ready = 1, all other outputs 0.
- Reset asserted mid-operation: enables drop immediately; a pending write is not committed; no response is issued.
- Byte lanes are little-endian: addr[1:0] = k selects bits [8k+7:8k]; a half at addr[1] = h selects [16h+15:16h].
- Request accept: req_valid & req_ready at a posedge captures addr, size, signed, write, wdata.
- Error check happens at accept:
  - size 3 is an error;
  - half with addr[0] = 1 is an error;
  - word with addr[1:0] != 0 is an error.
- FSM states: IDLE, READ, WRITE, ERR, RESP.
- IDLE -> ERR on an accepted erroneous request.
- IDLE -> WRITE on an accepted word store.
- IDLE -> READ on an accepted load or sub-word store.
- READ:
  - Drives mem_read_enable = 1, mem_write_enable = 0, mem_address.
  - Samples mem_rdata at the end of the cycle.
  - Load -> RESP. Sub-word store -> WRITE.
- WRITE:
  - Drives mem_write_enable = 1, mem_read_enable = 0.
  - mem_wdata = full wdata for a word store, or the sampled word with the target lane(s) replaced by wdata[7:0] / wdata[15:0].
  - Memory commits on the edge ending this cycle. Next state RESP.
- ERR -> RESP with resp_error = 1; no memory enable asserted at any point.
- RESP:
  - resp_valid = 1 for exactly one cycle; resp_rdata valid for loads.
  - Next state IDLE.
- Response has no backpressure.
- Latency from accept edge to resp_valid high:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 2 cycles.
- Throughput is one request per latency + 1 cycles; req_ready = 0 outside IDLE.
- mem_read_enable and mem_write_enable are never both 1.
- All mem_* outputs are registered or decoded from registered state only; there are no combinational paths from req_* to mem_*.
- Load extension: byte/half is zero- or sign-extended to 32 bits per req_signed. req_signed is ignored for words and for stores.
- req_valid while busy is held off, not dropped. The requester must keep the request stable until accepted.

Decomposition:
- Shared package riscy_mem_pkg:
  - MEM_SIZE_BYTE = 2'd0, MEM_SIZE_HALF = 2'd1, MEM_SIZE_WORD = 2'd2;
  - FSM state encoding constants;
  - WORD_BYTES = 4.
- One combinational sub-module, mem_lane_align. It contains the lane extract + sign/zero extend function and the store merge function. It is reused by the future instruction fetch path.

Test Plan:
- Preload memory word 1 = 32'h8899AABB; load byte, signed, addr 0x6 -> resp_rdata 32'hFFFFFF99, resp_valid exactly 2 cycles after accept.
- Same word; load half, unsigned, addr 0x4 -> 32'h0000AABB; load word, addr 0x4 -> 32'h8899AABB.
- Store byte 8'h5A to addr 0x5 (word 1 = 32'h8899AABB) -> one READ cycle, then one WRITE cycle with mem_wdata 32'h88995ABB; resp_valid 3 cycles after accept; readback matches.
- Load word addr 0x2, and store half addr 0x3 -> resp_error = 1, resp_rdata 0, mem enables never asserted, memory unchanged.
- Back-to-back requests held on req_valid -> req_ready low while busy; second request accepted the cycle after the first resp_valid; the read and write enables are never asserted in the same cycle.
- Assert rst during the WRITE state of a sub-word store -> mem_write_enable falls immediately, memory word unchanged, no resp_valid; req_ready = 1 after reset release.

Source files
------------

// File: rtl/riscy_mem_pkg.sv
// Shared definitions for the memory access path: request size codes,
// initiator FSM states and the alignment rule applied to incoming requests.
package riscy_mem_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;
  localparam logic [1:0] MEM_SIZE_RSVD = 2'd3;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_ERR   = 3'd3,
    ST_RESP  = 3'd4
  } mem_state_t;

  // Reserved size, odd half or unaligned word are all rejected.
  function automatic logic req_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      MEM_SIZE_BYTE: return 1'b0;
      MEM_SIZE_HALF: return offset[0];
      MEM_SIZE_WORD: return (offset != 2'b00);
      default:       return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane helper: extracts/extends a loaded byte or half and
// merges sub-word store data into a previously read word.
module mem_lane_align
  import riscy_mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]               word,
  input  logic [$clog2(WORD_BYTES)-1:0]   offset,
  input  logic [1:0]                      size,
  input  logic                            sign_ext,
  input  logic [DATA_W-1:0]               wdata,
  output logic [DATA_W-1:0]               load_data,
  output logic [DATA_W-1:0]               merged
);

  function automatic logic [DATA_W-1:0] lane_extract(
    input logic [DATA_W-1:0] w, input logic [1:0] off,
    input logic [1:0] sz, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (sz)
      MEM_SIZE_BYTE: return sx ? {{(DATA_W-8){b[7]}}, b} : {{(DATA_W-8){1'b0}}, b};
      MEM_SIZE_HALF: return sx ? {{(DATA_W-16){h[15]}}, h} : {{(DATA_W-16){1'b0}}, h};
      default:       return w;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] w, input logic [1:0] off,
    input logic [1:0] sz, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] m;
    m = w;
    case (sz)
      MEM_SIZE_BYTE: m[{off, 3'b000} +: 8] = d[7:0];
      MEM_SIZE_HALF: m[{off[1], 4'b0000} +: 16] = d[15:0];
      default:       m = d;
    endcase
    return m;
  endfunction

  assign load_data = lane_extract(word, offset, size, sign_ext);
  assign merged    = lane_merge(word, offset, size, wdata);

endmodule

// File: rtl/mem_access_initiator.sv
// Load/store master for the word-addressed main memory: accepts byte-addressed
// requests, checks alignment, does read-modify-write for sub-word stores.
module mem_access_initiator
  import riscy_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  mem_state_t        state;
  logic              cap_write;
  logic [1:0]        cap_size;
  logic              cap_signed;
  logic [1:0]        cap_offset;
  logic [DATA_W-1:0] cap_wdata;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;
  logic              accept;
  logic              req_err;

  assign accept  = req_valid & req_ready;
  assign req_err = req_misaligned(req_size, req_addr[1:0]);

  // Request payload is captured at accept and never needs a reset value.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_write  <= req_write;
      cap_size   <= req_size;
      cap_signed <= req_signed;
      cap_offset <= req_addr[1:0];
      cap_wdata  <= req_wdata;
    end
  end

  mem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .word      (mem_rdata),
    .offset    (cap_offset),
    .size      (cap_size),
    .sign_ext  (cap_signed),
    .wdata     (cap_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      resp_rdata       <= '0;
      resp_error       <= 1'b0;
      mem_address      <= '0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_wdata        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready   <= 1'b0;
            mem_address <= {2'b00, req_addr[ADDR_W-1:2]};
            if (req_err) begin
              state <= ST_ERR;
            end else if (req_write && req_size == MEM_SIZE_WORD) begin
              state            <= ST_WRITE;
              mem_write_enable <= 1'b1;
              mem_wdata        <= req_wdata;
            end else begin
              state           <= ST_READ;
              mem_read_enable <= 1'b1;
            end
          end
        end
        // mem_rdata is combinational, so it is valid by the end of this cycle.
        ST_READ: begin
          mem_read_enable <= 1'b0;
          if (cap_write) begin
            state            <= ST_WRITE;
            mem_write_enable <= 1'b1;
            mem_wdata        <= merged;
          end else begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
          end
        end
        ST_WRITE: begin
          mem_write_enable <= 1'b0;
          state            <= ST_RESP;
          resp_valid       <= 1'b1;
          resp_rdata       <= '0;
        end
        ST_ERR: begin
          state      <= ST_RESP;
          resp_valid <= 1'b1;
          resp_error <= 1'b1;
          resp_rdata <= '0;
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end
        default: begin
          state            <= ST_IDLE;
          req_ready        <= 1'b1;
          resp_valid       <= 1'b0;
          resp_error       <= 1'b0;
          resp_rdata       <= '0;
          mem_read_enable  <= 1'b0;
          mem_write_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule
